// File: rtl/axis_rr_arbiter.sv
// Round-robin packet arbiter: N AXI-Stream slaves onto one registered master.
// A granted input owns the output until its s_last beat is accepted.
module axis_rr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int INPUTS     = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [INPUTS*DATA_WIDTH-1:0] s_data,
   input  logic [INPUTS-1:0]            s_valid,
   input  logic [INPUTS-1:0]            s_last,
   output logic [INPUTS-1:0]            s_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic                         m_valid,
   output logic                         m_last,
   input  logic                         m_ready,
   output logic [INPUTS-1:0]            grant,
   output logic                         busy
);

   localparam int PW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                  state_q;
   logic [INPUTS-1:0]       grant_q;
   logic [PW-1:0]           ptr_q;
   logic [PW-1:0]           owner_q;
   logic [DATA_WIDTH-1:0]   m_data_q;
   logic                    m_valid_q;
   logic                    m_last_q;

   logic                    out_free;
   logic                    accept;
   logic                    pick_found;
   logic [PW-1:0]           pick_idx;

   // Output register can take a beat when empty or draining this cycle.
   assign out_free = !m_valid_q || m_ready;

   generate
      for (genvar gi = 0; gi < INPUTS; gi++) begin : g_ready
         assign s_ready[gi] = !reset && (state_q == LOCKED) && grant_q[gi] && out_free;
      end
   endgenerate

   assign accept = |(s_ready & s_valid);

   // Scan upward from ptr+1 with explicit wrap so non-power-of-two INPUTS stay in range.
   always_comb begin
      int          cand;
      logic [PW-1:0] cand_idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 1; k <= INPUTS; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= INPUTS) cand = cand - INPUTS;
         cand_idx = PW'(cand);
         if (!pick_found && s_valid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= PW'(INPUTS - 1);
         owner_q   <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            m_data_q  <= s_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            m_last_q  <= s_last[owner_q];
            m_valid_q <= 1'b1;
         end else if (m_ready) begin
            m_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  state_q <= LOCKED;
                  owner_q <= pick_idx;
                  grant_q <= {{(INPUTS-1){1'b0}}, 1'b1} << pick_idx;
               end
            end
            LOCKED: begin
               if (accept && s_last[owner_q]) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= owner_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_data  = m_data_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign grant   = grant_q;
   assign busy    = (state_q == LOCKED);

endmodule
